// File: rtl/cache_pkg.sv
// Shared types for the cache line-fill slice: fill FSM encoding and line-memory access-size codes.
package cache_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_FILL = 2'd2,
      ST_DONE = 2'd3
   } fill_state_t;

   localparam logic [1:0] WL_BYTE = 2'b00;
   localparam logic [1:0] WL_HALF = 2'b01;
   localparam logic [1:0] WL_WORD = 2'b10;

endpackage

// File: rtl/cache_wrapcnt.sv
// Wrapping beat-index counter: loads a start index, increments per beat and flags the final beat of a line.
module cache_wrapcnt #(
   parameter int unsigned CW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic [CW-1:0] start,
   input  logic          inc,
   output logic [CW-1:0] idx,
   output logic          last_c
);

   logic [CW-1:0] start_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         idx     <= '0;
         start_q <= '0;
      end else if (load) begin
         idx     <= start;
         start_q <= start;
      end else if (inc) begin
         idx <= idx + CW'(1);
      end
   end

   // Final beat is the one just before the index wraps back to where it started.
   assign last_c = ((idx + CW'(1)) == start_q);

endmodule

// File: rtl/cache_linefill.sv
// Cache line-fill engine: issues one burst read per miss and streams the beats into the line memory.
// Optional build macro CACHE_CRITICAL_WORD_FIRST_EN starts the burst at the requested word and wraps.
module cache_linefill
   import cache_pkg::*;
#(
   parameter int unsigned ADDRBITS    = 32,
   parameter int unsigned DATABITS    = 32,
   parameter int unsigned LSBBITS     = 7,
   parameter int unsigned WORDLENBITS = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   fill_req,
   input  logic [ADDRBITS-1:0]    fill_addr,
   output logic                   fill_busy,
   output logic                   fill_done,
   output logic                   crit_valid,
   output logic [DATABITS-1:0]    crit_data,
   output logic                   mem_rd,
   output logic [ADDRBITS-1:0]    mem_addr,
   input  logic                   mem_ack,
   input  logic                   mem_valid,
   input  logic [DATABITS-1:0]    mem_in,
   output logic [LSBBITS-1:0]     line_mem_wraddr,
   output logic                   line_mem_we,
   output logic [DATABITS-1:0]    line_mem_in,
   output logic [WORDLENBITS-1:0] line_mem_in_wordlen
);

   localparam int unsigned CW = LSBBITS - 2;

   fill_state_t   state, state_next;
   logic [CW-1:0] req_idx_c, start_idx_c, crit_idx, beat_idx;
   logic          accept_c, beat_c, last_c, last_wr;
   logic          unused_c;

   assign req_idx_c = fill_addr[LSBBITS-1:2];
   assign unused_c  = ^fill_addr[1:0];

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
   assign start_idx_c = req_idx_c;
`else
   assign start_idx_c = '0;
`endif

   assign line_mem_in_wordlen = WORDLENBITS'(WL_WORD);

   cache_wrapcnt #(.CW(CW)) u_wrapcnt (
      .clk    (clk),
      .reset  (reset),
      .load   (accept_c),
      .start  (start_idx_c),
      .inc    (beat_c),
      .idx    (beat_idx),
      .last_c (last_c)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   // Next state; beats are accepted only in FILL and only until the last one has been taken.
   always_comb begin
      state_next = state;
      accept_c   = 1'b0;
      beat_c     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (fill_req) begin
               accept_c   = 1'b1;
               state_next = ST_REQ;
            end
         end
         ST_REQ: begin
            if (mem_rd && mem_ack) state_next = ST_FILL;
         end
         ST_FILL: begin
            beat_c = mem_valid && !last_wr;
            if (last_wr) state_next = ST_DONE;
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Registered outputs track the next state so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (reset) begin
         fill_busy       <= 1'b0;
         fill_done       <= 1'b0;
         mem_rd          <= 1'b0;
         mem_addr        <= '0;
         crit_idx        <= '0;
         crit_valid      <= 1'b0;
         crit_data       <= '0;
         line_mem_we     <= 1'b0;
         line_mem_wraddr <= '0;
         line_mem_in     <= '0;
         last_wr         <= 1'b0;
      end else begin
         fill_busy   <= (state_next != ST_IDLE);
         fill_done   <= (state_next == ST_DONE);
         mem_rd      <= (state_next == ST_REQ);
         line_mem_we <= beat_c;
         crit_valid  <= beat_c && (beat_idx == crit_idx);
         last_wr     <= (state_next == ST_FILL) && (last_wr || (beat_c && last_c));
         if (accept_c) begin
            crit_idx <= req_idx_c;
            mem_addr <= {fill_addr[ADDRBITS-1:LSBBITS], start_idx_c, 2'b00};
         end
         if (beat_c) begin
            line_mem_in     <= mem_in;
            line_mem_wraddr <= {beat_idx, 2'b00};
         end
         if (beat_c && (beat_idx == crit_idx)) crit_data <= mem_in;
      end
   end

endmodule

// File: tb/tb_cache_linefill.sv
// Scoreboard bench for cache_linefill: a driver issues fills and queues the expected responses,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_cache_linefill;

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
   localparam bit CWF = 1'b1;
`else
   localparam bit CWF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        fill_req;
   logic [31:0] fill_addr;
   logic        fill_busy, fill_done, crit_valid, mem_rd, mem_ack, mem_valid, line_mem_we;
   logic [31:0] crit_data, mem_addr, mem_in, line_mem_in;
   logic [6:0]  line_mem_wraddr;
   logic [1:0]  line_mem_in_wordlen;

   typedef struct packed {
      logic [6:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t         wq[$];
   wr_t         cq[$];
   logic [31:0] aq[$];
   int          done_pend = 0;
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          last_wr_cyc = -10;
   bit          mon_en = 1'b0;
   bit          idle_chk = 1'b0;

   cache_linefill dut (
      .clk                 (clk),
      .reset               (reset),
      .fill_req            (fill_req),
      .fill_addr           (fill_addr),
      .fill_busy           (fill_busy),
      .fill_done           (fill_done),
      .crit_valid          (crit_valid),
      .crit_data           (crit_data),
      .mem_rd              (mem_rd),
      .mem_addr            (mem_addr),
      .mem_ack             (mem_ack),
      .mem_valid           (mem_valid),
      .mem_in              (mem_in),
      .line_mem_wraddr     (line_mem_wraddr),
      .line_mem_we         (line_mem_we),
      .line_mem_in         (line_mem_in),
      .line_mem_in_wordlen (line_mem_in_wordlen)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got time %0t required < 500000", $time);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset();
      chk("rst_busy",    64'(fill_busy),       64'd0);
      chk("rst_done",    64'(fill_done),       64'd0);
      chk("rst_crit_v",  64'(crit_valid),      64'd0);
      chk("rst_crit_d",  64'(crit_data),       64'd0);
      chk("rst_mem_rd",  64'(mem_rd),          64'd0);
      chk("rst_mem_addr",64'(mem_addr),        64'd0);
      chk("rst_we",      64'(line_mem_we),     64'd0);
      chk("rst_wraddr",  64'(line_mem_wraddr), 64'd0);
      chk("rst_wdata",   64'(line_mem_in),     64'd0);
      chk("wordlen",     64'(line_mem_in_wordlen), 64'd2);
   endtask

   // Monitor: every DUT response must match the head of the corresponding expectation queue.
   always @(negedge clk) begin
      wr_t w;
      if (mon_en) begin
         if (idle_chk) begin
            chk("busy_after_done", 64'(fill_busy), 64'd0);
            idle_chk = 1'b0;
         end
         if (mem_rd) begin
            if (aq.size() == 0) chk("unexpected_mem_rd", 64'(mem_rd), 64'd0);
            else begin
               chk("mem_addr", 64'(mem_addr), 64'(aq[0]));
               if (mem_ack) void'(aq.pop_front());
            end
         end
         if (line_mem_we) begin
            if (wq.size() == 0) chk("unexpected_write", 64'(line_mem_we), 64'd0);
            else begin
               w = wq.pop_front();
               chk("wraddr", 64'(line_mem_wraddr), 64'(w.addr));
               chk("wdata",  64'(line_mem_in),     64'(w.data));
            end
            last_wr_cyc = cyc;
         end
         if (crit_valid) begin
            if (cq.size() == 0) chk("unexpected_crit", 64'(crit_valid), 64'd0);
            else begin
               w = cq.pop_front();
               chk("crit_data", 64'(crit_data), 64'(w.data));
               chk("crit_with_write", 64'({line_mem_we, line_mem_wraddr}), 64'({1'b1, w.addr}));
            end
         end
         if (fill_done) begin
            if (done_pend == 0) chk("unexpected_done", 64'(fill_done), 64'd0);
            else begin
               done_pend--;
               chk("done_after_last_write", 64'(cyc - last_wr_cyc), 64'd1);
               chk("writes_left_at_done",   64'(wq.size()), 64'd0);
               chk("crit_left_at_done",     64'(cq.size()), 64'd0);
               chk("busy_in_done",          64'(fill_busy), 64'd1);
               idle_chk = 1'b1;
            end
         end
      end
   end

   // gap_mode: 0 back-to-back, 1 two-cycle gap before every 4th beat, 2 random gaps.
   // abort_after: nonzero asserts reset once that many beats have been written.
   task automatic do_fill(input logic [31:0] addr, input int ack_dly, input int gap_mode,
                          input int abort_after);
      int          widx, start, idx;
      logic [31:0] d;
      wr_t         e;
      widx  = int'(addr[6:2]);
      start = CWF ? widx : 0;
      aq.push_back((addr & 32'hFFFF_FF80) | 32'(start * 4));
      fill_addr = addr;
      fill_req  = 1'b1;
      tick();
      fill_req  = 1'b0;
      fill_addr = $urandom;
      for (int i = 0; i < ack_dly; i++) begin
         mem_valid = 1'b1;
         mem_in    = $urandom;
         tick();
      end
      mem_valid = 1'b0;
      mem_ack   = 1'b1;
      tick();
      mem_ack = 1'b0;
      for (int k = 0; k < 32; k++) begin
         if ((gap_mode == 1 && k % 4 == 3) || (gap_mode == 2 && $urandom_range(3) == 0)) begin
            tick();
            tick();
         end
         d         = $urandom;
         idx       = (start + k) % 32;
         mem_valid = 1'b1;
         mem_in    = d;
         fill_req  = (k == 5);
         e.addr    = 7'(idx * 4);
         e.data    = d;
         wq.push_back(e);
         if (idx == widx) cq.push_back(e);
         tick();
         mem_valid = 1'b0;
         fill_req  = 1'b0;
         if (abort_after == k + 1) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            wq.delete();
            cq.delete();
            @(negedge clk);
            check_reset();
            tick();
            return;
         end
      end
      // Last write is visible now; DONE follows, and requests/beats around it must be ignored.
      done_pend++;
      fill_req = 1'b1;
      tick();
      mem_valid = 1'b1;
      mem_in    = $urandom;
      tick();
      fill_req = 1'b0;
      tick();
      mem_valid = 1'b0;
      tick();
   endtask

   initial begin
      reset     = 1'b1;
      fill_req  = 1'b0;
      fill_addr = '0;
      mem_ack   = 1'b0;
      mem_valid = 1'b0;
      mem_in    = '0;
      repeat (3) tick();
      @(negedge clk);
      check_reset();
      tick();
      reset  = 1'b0;
      mon_en = 1'b1;
      tick();

      do_fill(32'h1000_0044, 3, 0, 0);
      do_fill(32'h1000_0044, 1, 1, 0);
      do_fill(32'h2000_0100 | 32'($urandom_range(127)), 2, 0, 10);
      do_fill(32'h1000_0044, 0, 0, 0);
      do_fill(32'hABCD_EF7C, 2, 2, 0);
      do_fill(32'h5555_5501, 4, 1, 0);
      for (int n = 0; n < 6; n++)
         do_fill($urandom, int'($urandom_range(5)), int'($urandom_range(2)), 0);

      repeat (5) tick();
      chk("end_writes_pending", 64'(wq.size()), 64'd0);
      chk("end_crit_pending",   64'(cq.size()), 64'd0);
      chk("end_req_pending",    64'(aq.size()), 64'd0);
      chk("end_done_pending",   64'(done_pend), 64'd0);
      chk("end_busy",           64'(fill_busy), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cache_linefill.md
CACHE_LINEFILL -- requirements
Module: cache_linefill

Interface
REQ-001 SHALL have parameter ADDRBITS, default 32, meaning byte-address width.
REQ-002 SHALL have parameter DATABITS, default 32, meaning data word width; only 32 is supported.
REQ-003 SHALL have parameter LSBBITS, default 7, meaning line byte-offset width (line = 2**LSBBITS bytes, LINEWORDS = 2**(LSBBITS-2)).
REQ-004 SHALL have parameter WORDLENBITS, default 2, meaning access-size code width.
REQ-005 SHALL use one clock; reset is synchronous and active-high; ports are named clk and reset.
REQ-006 SHALL have port clk, input, 1, rising-edge clock.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port fill_req, input, 1, start a line fill (sampled only in IDLE).
REQ-009 SHALL have port fill_addr, input, ADDRBITS, byte address of the missing access.
REQ-010 SHALL have port fill_busy, output, 1, high while not IDLE.
REQ-011 SHALL have port fill_done, output, 1, one-cycle pulse at fill completion.
REQ-012 SHALL have port crit_valid and crit_data, output, 1 and DATABITS, one-cycle forward of the requested word.
REQ-013 SHALL have port mem_rd, mem_addr, output, 1 and ADDRBITS, burst read request and start address.
REQ-014 SHALL have port mem_ack, input, 1, burst request accepted.
REQ-015 SHALL have port mem_valid, mem_in, input, 1 and DATABITS, one data beat per cycle with mem_valid high.
REQ-016 SHALL have port line_mem_wraddr, line_mem_we, line_mem_in, line_mem_in_wordlen, output, LSBBITS/1/DATABITS/WORDLENBITS, write port toward the line memory.

Function
REQ-017 SHALL implement FSM IDLE -> REQ (fill_req) -> FILL (mem_rd & mem_ack) -> DONE (last beat written) -> IDLE (next cycle).
REQ-018 SHALL latch fill_addr on acceptance; fill_addr[1:0] is ignored.
REQ-019 SHALL hold mem_rd high and mem_addr stable in REQ until mem_ack; mem_rd low in all other states.
REQ-020 SHALL drive mem_addr = {line base, start word index, 2'b00}, with start index per REQ-031/032.
REQ-021 SHALL expect LINEWORDS beats; a beat index counter of LSBBITS-2 bits wraps modulo LINEWORDS.
REQ-022 SHALL register each beat: mem_valid at cycle t gives line_mem_we=1, line_mem_in=mem_in, line_mem_wraddr={index,2'b00} at t+1.
REQ-023 SHALL drive line_mem_in_wordlen = 2'b10 (word) constantly.
REQ-024 SHALL ignore mem_valid in IDLE, REQ and DONE; no line write occurs.
REQ-025 SHALL tolerate gaps (mem_valid low) inside FILL without advancing the counter.
REQ-026 SHALL assert crit_valid with crit_data at t+1 for the beat whose index equals the requested word index, exactly once per fill.
REQ-027 SHALL assert fill_done in the DONE cycle, which is the cycle after the final line_mem_we pulse; fill_busy falls the following cycle.
REQ-028 SHALL ignore fill_req while fill_busy; a fill_req in DONE is not queued.

Reset
REQ-029 SHALL, on reset, go to IDLE and clear counter; fill_busy, fill_done, crit_valid, mem_rd, line_mem_we = 0; mem_addr, crit_data, line_mem_wraddr, line_mem_in = 0.
REQ-030 SHALL, on reset mid-fill, suppress any pending registered write in the same cycle; a partially filled line is not marked done.

Configuration
REQ-031 SHALL, with CACHE_CRITICAL_WORD_FIRST_EN defined, start the burst at the requested word index and wrap (e.g. index 30 of 32: 30,31,0,...,29); crit_valid then follows the first beat.
REQ-032 SHALL, without CACHE_CRITICAL_WORD_FIRST_EN, start at index 0 and fill in ascending order.

Structure
REQ-033 SHALL take the FSM state encoding and the wordlen codes (BYTE=2'b00, HALF=2'b01, WORD=2'b10) from shared package cache_pkg.
REQ-034 SHALL place the wrapping beat counter in sub-module cache_wrapcnt (load start, increment, last flag).

Verification
REQ-035 Fill addr 0x1000_0044, macro off, mem_ack after 3 cycles, 32 back-to-back beats -> mem_addr 0x1000_0000, writes to wraddr 0x00..0x7C, crit_valid on beat 17, fill_done one cycle after last write.
REQ-036 Same addr, macro on -> mem_addr 0x1000_0044, writes start at wraddr 0x44, wrap at 0x7C->0x00, crit_valid on first beat.
REQ-037 Beats with 2-cycle gaps every 4th beat -> exactly 32 writes, no duplicated/skipped wraddr.
REQ-038 fill_req pulsed during FILL and mem_valid pulsed in IDLE -> no new mem_rd, no line_mem_we.
REQ-039 reset asserted after beat 10 -> next cycle all outputs at reset values, no fill_done; new fill then completes normally.
